rom_bus_arbiter: RTL and testbench

- Owns the single external ROM/SRAM0 port and shares it between two requesters.
  - SNES accesses: already translated by the address decoder into a 24-bit ROM address plus writable qualifier. Top priority, bounded latency.
  - MCU accesses: ROM upload, savegame transfer. Background, req/ack handshake.
- Sequences the memory strobes with fixed cycle timing.
- Sits in the top level between the address decoder/SNES bus capture and the SRAM pins.

---
 rtl/rom_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_rom_bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_arbiter.sv
// rtl/rom_bus_arbiter.sv - SNES/MCU arbiter for the shared ROM/SRAM0 port with fixed strobe timing
// Optional MCU wait counter output enabled by ROM_ARB_PERFCNT_EN.
module rom_bus_arbiter #(
    parameter int ACC_CYCLES = 4,
    parameter int WE_CYCLES  = 2,
    parameter int REC_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        snes_req,
    input  logic        snes_we,
    input  logic [23:0] snes_addr,
    input  logic [7:0]  snes_wdata,
    input  logic        snes_writable,
    output logic [7:0]  snes_rdata,
    output logic        snes_rvalid,
    output logic        snes_overrun,
    input  logic        mcu_req,
    input  logic        mcu_we,
    input  logic [23:0] mcu_addr,
    input  logic [7:0]  mcu_wdata,
    output logic        mcu_ack,
    output logic [7:0]  mcu_rdata,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_doe,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    input  logic [7:0]  mem_din
`ifdef ROM_ARB_PERFCNT_EN
    ,
    output logic [15:0] mcu_wait_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

    localparam logic [7:0] ACC_LAST = 8'(ACC_CYCLES - 1);
    localparam logic [7:0] WE_LAST  = 8'(WE_CYCLES);
    localparam logic [7:0] REC_LAST = 8'(REC_CYCLES - 1);
    localparam logic       OWN_SNES = 1'b0;
    localparam logic       OWN_MCU  = 1'b1;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, rec_q, rec_d;
    logic        owner_q, owner_d, we_q, we_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        pend_q, pend_d, p_we_q, p_we_d, p_wr_q, p_wr_d;
    logic [23:0] p_addr_q, p_addr_d;
    logic [7:0]  p_wdata_q, p_wdata_d;
    logic [7:0]  snes_rdata_q, snes_rdata_d, mcu_rdata_q, mcu_rdata_d;
    logic        rvalid_q, rvalid_d, overrun_q, overrun_d;
    logic        ack_q, ack_d, blank_q, blank_d;

    // A pending request takes precedence over a same-cycle one (which is then dropped).
    logic        s_we, s_wr;
    logic [23:0] s_addr;
    logic [7:0]  s_wdata;
    assign s_we    = pend_q ? p_we_q    : snes_we;
    assign s_wr    = pend_q ? p_wr_q    : snes_writable;
    assign s_addr  = pend_q ? p_addr_q  : snes_addr;
    assign s_wdata = pend_q ? p_wdata_q : snes_wdata;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rec_q        <= '0;
            owner_q      <= OWN_SNES;
            we_q         <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            pend_q       <= 1'b0;
            p_we_q       <= 1'b0;
            p_wr_q       <= 1'b0;
            p_addr_q     <= '0;
            p_wdata_q    <= '0;
            snes_rdata_q <= '0;
            mcu_rdata_q  <= '0;
            rvalid_q     <= 1'b0;
            overrun_q    <= 1'b0;
            ack_q        <= 1'b0;
            blank_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rec_q        <= rec_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            pend_q       <= pend_d;
            p_we_q       <= p_we_d;
            p_wr_q       <= p_wr_d;
            p_addr_q     <= p_addr_d;
            p_wdata_q    <= p_wdata_d;
            snes_rdata_q <= snes_rdata_d;
            mcu_rdata_q  <= mcu_rdata_d;
            rvalid_q     <= rvalid_d;
            overrun_q    <= overrun_d;
            ack_q        <= ack_d;
            blank_q      <= blank_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rec_d        = rec_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        pend_d       = pend_q;
        p_we_d       = p_we_q;
        p_wr_d       = p_wr_q;
        p_addr_d     = p_addr_q;
        p_wdata_d    = p_wdata_q;
        snes_rdata_d = snes_rdata_q;
        mcu_rdata_d  = mcu_rdata_q;
        rvalid_d     = 1'b0;
        overrun_d    = overrun_q;
        ack_d        = 1'b0;
        blank_d      = ack_q;

        if (snes_req) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else if (state_q != S_IDLE) begin
                pend_d    = 1'b1;
                p_we_d    = snes_we;
                p_wr_d    = snes_writable;
                p_addr_d  = snes_addr;
                p_wdata_d = snes_wdata;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (pend_q || snes_req) begin
                    pend_d = 1'b0;
                    // Writes to non-writable space are swallowed without a bus cycle.
                    if (!(s_we && !s_wr)) begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                        owner_d = OWN_SNES;
                        we_d    = s_we;
                        addr_d  = s_addr;
                        if (s_we) dout_d = s_wdata;
                    end
                end else if (mcu_req && !ack_q && !blank_q) begin
                    // Blanking also covers the ack cycle itself, which matters when REC_CYCLES=0.
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    owner_d = OWN_MCU;
                    we_d    = mcu_we;
                    addr_d  = mcu_addr;
                    if (mcu_we) dout_d = mcu_wdata;
                end
            end
            S_ACCESS: begin
                if (cnt_q == ACC_LAST) begin
                    if (owner_q == OWN_SNES) begin
                        if (!we_q) begin
                            snes_rdata_d = mem_din;
                            rvalid_d     = 1'b1;
                        end
                    end else begin
                        ack_d = 1'b1;
                        if (!we_q) mcu_rdata_d = mem_din;
                    end
                    rec_d   = '0;
                    state_d = (REC_CYCLES == 0) ? S_IDLE : S_RECOVER;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RECOVER: begin
                if (rec_q == REC_LAST) state_d = S_IDLE;
                else                   rec_d   = rec_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset releases them at once.
    assign mem_oe_n = !(state_q == S_ACCESS && !we_q);
    assign mem_doe  = (state_q == S_ACCESS) && we_q;
    assign mem_we_n = !((state_q == S_ACCESS) && we_q && (cnt_q >= 8'd1) && (cnt_q <= WE_LAST));
    assign mem_addr = addr_q;
    assign mem_dout = dout_q;

    assign snes_rdata   = snes_rdata_q;
    assign snes_rvalid  = rvalid_q;
    assign snes_overrun = overrun_q;
    assign mcu_ack      = ack_q;
    assign mcu_rdata    = mcu_rdata_q;

`ifdef ROM_ARB_PERFCNT_EN
    logic [15:0] wait_q, wait_d;
    logic        serving_mcu;
    assign serving_mcu = (state_q != S_IDLE) && (owner_q == OWN_MCU);

    always_comb begin
        wait_d = wait_q;
        if (ack_d)
            wait_d = '0;
        else if (mcu_req && !serving_mcu && !ack_q && !blank_q && wait_q != 16'hFFFF)
            wait_d = wait_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) wait_q <= '0;
        else        wait_q <= wait_d;
    end

    assign mcu_wait_cnt = wait_q;
`endif

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// tb/tb_rom_bus_arbiter.sv - directed self-checking bench for rom_bus_arbiter
module tb_rom_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        snes_req, snes_we, snes_writable;
    logic [23:0] snes_addr;
    logic [7:0]  snes_wdata, snes_rdata;
    logic        snes_rvalid, snes_overrun;
    logic        mcu_req, mcu_we, mcu_ack;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata, mcu_rdata;
    logic [23:0] mem_addr;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_doe, mem_oe_n, mem_we_n;
`ifdef ROM_ARB_PERFCNT_EN
    logic [15:0] mcu_wait_cnt;
`endif

    always #5 CLK = ~CLK;

    rom_bus_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr),
        .snes_wdata(snes_wdata), .snes_writable(snes_writable),
        .snes_rdata(snes_rdata), .snes_rvalid(snes_rvalid), .snes_overrun(snes_overrun),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
        .mcu_ack(mcu_ack), .mcu_rdata(mcu_rdata),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_doe(mem_doe),
        .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_din(mem_din)
`ifdef ROM_ARB_PERFCNT_EN
        , .mcu_wait_cnt(mcu_wait_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        snes_req = 0; snes_we = 0; snes_writable = 0; snes_addr = '0; snes_wdata = '0;
        mcu_req = 0; mcu_we = 0; mcu_addr = '0; mcu_wdata = '0; mem_din = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        #1 RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    int ack_c, rv_c, acc_n, ack_n, doe_n, we_n_low, rv_n, strb_n;
    bit saw1, saw2;

    initial begin
        idle_inputs();
        #1 RST_N = 1'b0;
        tick();
        check("rst_strobes", {mem_oe_n, mem_we_n, mem_doe}, 3'b110);
        check("rst_mem", {mem_addr, mem_dout}, 32'h0);
        check("rst_rdata", {snes_rdata, mcu_rdata}, 16'h0);
        check("rst_flags", {snes_rvalid, mcu_ack, snes_overrun}, 3'b000);
`ifdef ROM_ARB_PERFCNT_EN
        check("rst_wait", mcu_wait_cnt, 16'h0);
`endif
        tick();
        RST_N = 1'b1;
        tick();

        // SNES read: address at cycle 1, oe low 1-4, rvalid at 5
        mem_din = 8'hA5; snes_addr = 24'h123456; snes_we = 0; snes_req = 1;
        tick();
        snes_req = 0;
        check("rd_addr_c1", mem_addr, 24'h123456);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("rd_oe_rv_c%0d", c), {mem_oe_n, snes_rvalid}, 2'b00);
            tick();
        end
        check("rd_rvalid_c5", snes_rvalid, 1'b1);
        check("rd_rdata_c5", snes_rdata, 8'hA5);
        check("rd_oe_off_c5", mem_oe_n, 1'b1);
        tick();
        check("rd_idle_c6", {mem_oe_n, mem_we_n, mem_doe, snes_rvalid}, 4'b1100);

        // SNES writable write: doe 4 clocks, we_n low exactly at cycles 2..3
        snes_req = 1; snes_we = 1; snes_writable = 1; snes_addr = 24'hE00010; snes_wdata = 8'h3C;
        tick();
        snes_req = 0;
        check("wr_addr", mem_addr, 24'hE00010);
        check("wr_dout", mem_dout, 8'h3C);
        doe_n = 0; we_n_low = 0; rv_n = 0;
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("wr_we_n_c%0d", c), mem_we_n, (c == 2 || c == 3) ? 1'b0 : 1'b1);
            doe_n += int'(mem_doe);
            we_n_low += int'(!mem_we_n);
            rv_n += int'(snes_rvalid);
            tick();
        end
        check("wr_doe_clocks", doe_n, 4);
        check("wr_we_clocks", we_n_low, 2);
        check("wr_no_rvalid", rv_n, 0);

        // Non-writable write: nothing on the bus
        snes_req = 1; snes_we = 1; snes_writable = 0; snes_addr = 24'hE00020; snes_wdata = 8'hC3;
        tick();
        snes_req = 0;
        strb_n = 0; rv_n = 0;
        for (int c = 1; c <= 6; c++) begin
            strb_n += int'(!mem_oe_n) + int'(!mem_we_n) + int'(mem_doe);
            rv_n += int'(snes_rvalid);
            tick();
        end
        check("nw_strobes", strb_n, 0);
        check("nw_rvalid", rv_n, 0);
        check("nw_addr_kept", mem_addr, 24'hE00010);
        snes_we = 0; snes_writable = 0;

        // MCU read granted, SNES read one cycle later waits behind it
        mcu_req = 1; mcu_we = 0; mcu_addr = 24'h000100; mem_din = 8'h5A;
        tick();
        snes_req = 1; snes_addr = 24'h200000;
        tick();
        snes_req = 0;
        ack_c = -1; rv_c = -1;
        for (int c = 2; c <= 30; c++) begin
            if (mcu_ack && ack_c < 0) begin
                ack_c = c; mcu_req = 0; mem_din = 8'hC3;
            end
            if (snes_rvalid && rv_c < 0) rv_c = c;
            if (c == 6) check("mix_recover_oe", mem_oe_n, 1'b1);
            if (c == 7) check("mix_snes_addr", mem_addr, 24'h200000);
            tick();
        end
        check("mix_ack_cycle", ack_c, 5);
        check("mix_mcu_rdata", mcu_rdata, 8'h5A);
        check("mix_rvalid_cycle", rv_c, 11);
        check("mix_snes_rdata", snes_rdata, 8'hC3);

        // Simultaneous requests: SNES first, single MCU ack, no regrant in blank cycle
        snes_req = 1; snes_we = 0; snes_addr = 24'h000AAA;
        mcu_req = 1; mcu_we = 1; mcu_addr = 24'h000BBB; mcu_wdata = 8'h77; mem_din = 8'h11;
        tick();
        snes_req = 0;
        ack_c = -1; rv_c = -1; acc_n = 0; ack_n = 0;
        for (int c = 1; c <= 20; c++) begin
            acc_n += int'(!mem_oe_n || mem_doe);
            if (snes_rvalid && rv_c < 0) rv_c = c;
            if (mcu_ack) begin
                ack_n++;
                if (ack_c < 0) ack_c = c;
`ifdef ROM_ARB_PERFCNT_EN
                check("perf_clear_at_ack", mcu_wait_cnt, 16'd0);
`endif
            end
            if (c == 7) begin
                check("sim_mcu_addr", mem_addr, 24'h000BBB);
                check("sim_mcu_dout", mem_dout, 8'h77);
`ifdef ROM_ARB_PERFCNT_EN
                check("perf_wait_7", mcu_wait_cnt, 16'd7);
`endif
            end
            if (ack_c >= 0 && c == ack_c + 2) mcu_req = 0;
            tick();
        end
        check("sim_rvalid_cycle", rv_c, 5);
        check("sim_snes_rdata", snes_rdata, 8'h11);
        check("sim_ack_cycle", ack_c, 11);
        check("sim_ack_count", ack_n, 1);
        check("sim_access_clocks", acc_n, 8);

        // Overrun: second SNES request while the first is pending is dropped
        mcu_req = 1; mcu_we = 1; mcu_addr = 24'h300000; mcu_wdata = 8'h55;
        tick();
        snes_req = 1; snes_we = 0; snes_addr = 24'h400001;
        tick();
        snes_addr = 24'h400002;
        check("ovr_clear_c2", snes_overrun, 1'b0);
        tick();
        snes_req = 0;
        check("ovr_set_c3", snes_overrun, 1'b1);
        saw1 = 0; saw2 = 0;
        for (int c = 3; c <= 25; c++) begin
            if (mem_addr == 24'h400001 && !mem_oe_n) saw1 = 1;
            if (mem_addr == 24'h400002) saw2 = 1;
            if (mcu_ack) mcu_req = 0;
            tick();
        end
        check("ovr_first_served", saw1, 1'b1);
        check("ovr_second_dropped", saw2, 1'b0);
        check("ovr_sticky", snes_overrun, 1'b1);
        do_reset();
        check("ovr_cleared_by_rst", snes_overrun, 1'b0);

        // Reset during a write at cnt=1 drops the strobes immediately
        mcu_req = 1; mcu_we = 1; mcu_addr = 24'h500000; mcu_wdata = 8'h99;
        tick();
        check("rstw_doe_c1", {mem_doe, mem_we_n}, 2'b11);
        tick();
        check("rstw_we_low_c2", mem_we_n, 1'b0);
        RST_N = 1'b0; mcu_req = 0;
        #1;
        check("rstw_strobes_off", {mem_we_n, mem_doe, mem_oe_n}, 3'b101);
        check("rstw_addr_cleared", mem_addr, 24'h0);
        #2 RST_N = 1'b1;
        ack_n = 0; strb_n = 0;
        for (int c = 0; c < 10; c++) begin
            ack_n += int'(mcu_ack);
            strb_n += int'(!mem_oe_n) + int'(!mem_we_n) + int'(mem_doe);
            tick();
        end
        check("rstw_no_ack", ack_n, 0);
        check("rstw_no_strobes", strb_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
